// File: rtl/inst_dec_pkg.sv
// Shared types and constants for the instruction-decode stage.
// Optional feature macro used by this slice: INST_DEC_PIPE_ILLEGAL_EN.
package inst_dec_pkg;

    // Instruction format code carried with every decoded entry.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Buffer occupancy of the main/skid storage pair.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Decoded fields stored per buffered instruction (pc/imm are kept
    // separately because their width follows XLEN).
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] func3;
        logic [6:0] func7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        fmt_e       fmt;
        logic       illegal;
    } dec_fields_t;

endpackage

// File: rtl/inst_imm_gen.sv
// Combinational format classifier and sign-extended immediate generator.
// Illegal-encoding detection is compiled in with INST_DEC_PIPE_ILLEGAL_EN.
module inst_imm_gen
    import inst_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    fmt_e        fmt_s;
    logic [31:0] imm32_s;
    logic [XLEN-1:0] imm_ext_s;

    // Classify the instruction format from its major opcode.
    always_comb begin
        fmt_s = FMT_R;
        case (inst[6:0])
            OPC_OP:                                  fmt_s = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt_s = FMT_I;
            OPC_STORE:                               fmt_s = FMT_S;
            OPC_BRANCH:                              fmt_s = FMT_B;
            OPC_LUI, OPC_AUIPC:                      fmt_s = FMT_U;
            OPC_JAL:                                 fmt_s = FMT_J;
            default:                                 fmt_s = FMT_R;
        endcase
    end

    // Assemble the 32-bit immediate for the detected format.
    always_comb begin
        imm32_s = 32'd0;
        case (fmt_s)
            FMT_I:   imm32_s = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32_s = {inst[31:12], 12'd0};
            FMT_J:   imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    // Signed cast extends bit 31 up to XLEN (a no-op when XLEN is 32).
    assign imm_ext_s = XLEN'($signed(imm32_s));

`ifdef INST_DEC_PIPE_ILLEGAL_EN
    // Flag unsupported encodings and force them to a neutral R/zero decode.
    always_comb begin
        illegal = (inst[1:0] != 2'b11) || ((fmt_s == FMT_R) && (inst[6:0] != OPC_OP));
        if (illegal) begin
            fmt = FMT_R;
            imm = {XLEN{1'b0}};
        end else begin
            fmt = fmt_s;
            imm = imm_ext_s;
        end
    end
`else
    // Without illegal detection, unknown opcodes simply decode as R.
    always_comb begin
        illegal = 1'b0;
        fmt     = fmt_s;
        imm     = imm_ext_s;
    end
`endif

endmodule

// File: rtl/inst_dec_pipe.sv
// Registered instruction-decode stage with valid/ready on both sides and a
// two-entry (main + skid) buffer. Optional macro: INST_DEC_PIPE_ILLEGAL_EN.
module inst_dec_pipe
    import inst_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    occ_e            state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    dec_fields_t     main_q, main_d, skid_q, skid_d, new_s;
    logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    fmt_e            gen_fmt_s;
    logic [XLEN-1:0] gen_imm_s;
    logic            gen_illegal_s;
    logic            accept_s, deliver_s;

    inst_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst    (in_inst),
        .fmt     (gen_fmt_s),
        .imm     (gen_imm_s),
        .illegal (gen_illegal_s)
    );

    // Decode the incoming word so only stored fields ever reach the outputs.
    always_comb begin
        new_s.opcode  = in_inst[6:0];
        new_s.func3   = in_inst[14:12];
        new_s.func7   = in_inst[31:25];
        new_s.rs1     = in_inst[19:15];
        new_s.rs2     = in_inst[24:20];
        new_s.rd      = in_inst[11:7];
        new_s.fmt     = gen_fmt_s;
        new_s.illegal = gen_illegal_s;
    end

    assign accept_s  = in_valid && in_ready_q;
    assign deliver_s = out_valid_q && out_ready;

    // Occupancy next-state and main/skid load selection; flush wins over all.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        main_pc_d  = main_pc_q;
        skid_pc_d  = skid_pc_q;
        main_imm_d = main_imm_q;
        skid_imm_d = skid_imm_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        main_d     = new_s;
                        main_pc_d  = in_pc;
                        main_imm_d = gen_imm_s;
                        state_d    = OCC_ONE;
                    end else begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (accept_s && deliver_s) begin
                        main_d     = new_s;
                        main_pc_d  = in_pc;
                        main_imm_d = gen_imm_s;
                        state_d    = OCC_ONE;
                    end else if (accept_s) begin
                        skid_d     = new_s;
                        skid_pc_d  = in_pc;
                        skid_imm_d = gen_imm_s;
                        state_d    = OCC_TWO;
                    end else if (deliver_s) begin
                        state_d = OCC_EMPTY;
                    end else begin
                        state_d = OCC_ONE;
                    end
                end
                OCC_TWO: begin
                    if (deliver_s) begin
                        main_d     = skid_q;
                        main_pc_d  = skid_pc_q;
                        main_imm_d = skid_imm_q;
                        state_d    = OCC_ONE;
                    end else begin
                        state_d = OCC_TWO;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != OCC_TWO);
        out_valid_d = (state_d != OCC_EMPTY);
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '{opcode: 7'd0, func3: 3'd0, func7: 7'd0, rs1: 5'd0, rs2: 5'd0,
                             rd: 5'd0, fmt: FMT_R, illegal: 1'b0};
            skid_q      <= '{opcode: 7'd0, func3: 3'd0, func7: 7'd0, rs1: 5'd0, rs2: 5'd0,
                             rd: 5'd0, fmt: FMT_R, illegal: 1'b0};
            main_pc_q   <= {XLEN{1'b0}};
            skid_pc_q   <= {XLEN{1'b0}};
            main_imm_q  <= {XLEN{1'b0}};
            skid_imm_q  <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            main_pc_q   <= main_pc_d;
            skid_pc_q   <= skid_pc_d;
            main_imm_q  <= main_imm_d;
            skid_imm_q  <= skid_imm_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = main_pc_q;
    assign opcode    = main_q.opcode;
    assign func3     = main_q.func3;
    assign func7     = main_q.func7;
    assign rs1       = main_q.rs1;
    assign rs2       = main_q.rs2;
    assign rd        = main_q.rd;
    assign fmt       = main_q.fmt;
    assign imm       = main_imm_q;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Directed self-checking bench for inst_dec_pipe (XLEN = 32).
module tb_inst_dec_pipe;

    localparam int XLEN = 32;
`ifdef INST_DEC_PIPE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, flush, out_valid, out_ready, illegal;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc, out_pc, imm;
    logic [6:0]      opcode, func7;
    logic [2:0]      func3, fmt;
    logic [4:0]      rs1, rs2, rd;
    int              checks = 0;
    int              failures = 0;

    inst_dec_pipe #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .opcode(opcode), .func3(func3),
        .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd), .fmt(fmt), .imm(imm),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Field bundle: {opcode, func3, func7, rs1, rs2, rd, fmt}
    function automatic logic [34:0] fields();
        return {opcode, func3, func7, rs1, rs2, rd, fmt};
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0;
        tick; tick;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if ({out_pc, imm, illegal} !== {32'd0, 32'd0, 1'b0}) begin failures++; $display("FAIL reset_pc_imm_ill got=%h/%h/%b exp=0/0/0", out_pc, imm, illegal); end
        checks++; if (fields() !== 35'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", fields()); end
    endtask

    task automatic test_decode;
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h0000_1000;   // addi x1,x0,5
        tick;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", out_valid); end
        checks++; if (fields() !== {7'h13, 3'd0, 7'h00, 5'd0, 5'd5, 5'd1, 3'd1}) begin failures++; $display("FAIL addi_fields got=%h", fields()); end
        checks++; if ({out_pc, imm, illegal} !== {32'h1000, 32'd5, 1'b0}) begin failures++; $display("FAIL addi_pc_imm got=%h/%h/%b exp=1000/5/0", out_pc, imm, illegal); end
        in_inst = 32'h0020A423; in_pc = 32'h0000_1004;                    // sw x2,8(x1)
        tick;
        checks++; if (fields() !== {7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd8, 3'd2}) begin failures++; $display("FAIL sw_fields got=%h", fields()); end
        checks++; if ({out_pc, imm} !== {32'h1004, 32'd8}) begin failures++; $display("FAIL sw_pc_imm got=%h/%h exp=1004/8", out_pc, imm); end
        in_inst = 32'hFE000EE3; in_pc = 32'h0000_1008;                    // beq x0,x0,-4
        tick;
        checks++; if (fields() !== {7'h63, 3'd0, 7'h7F, 5'd0, 5'd0, 5'd29, 3'd3}) begin failures++; $display("FAIL beq_fields got=%h", fields()); end
        checks++; if (imm !== 32'hFFFF_FFFC) begin failures++; $display("FAIL beq_imm got=%h exp=fffffffc", imm); end
        in_inst = 32'h123452B7; in_pc = 32'h0000_100C;                    // lui x5,0x12345
        tick;
        checks++; if (fields() !== {7'h37, 3'd5, 7'h09, 5'd8, 5'd3, 5'd5, 3'd4}) begin failures++; $display("FAIL lui_fields got=%h", fields()); end
        checks++; if (imm !== 32'h1234_5000) begin failures++; $display("FAIL lui_imm got=%h exp=12345000", imm); end
        in_inst = 32'h008000EF; in_pc = 32'h0000_1010;                    // jal x1,8
        tick;
        checks++; if (fields() !== {7'h6F, 3'd0, 7'h00, 5'd0, 5'd8, 5'd1, 3'd5}) begin failures++; $display("FAIL jal_fields got=%h", fields()); end
        checks++; if ({out_pc, imm} !== {32'h1010, 32'd8}) begin failures++; $display("FAIL jal_pc_imm got=%h/%h exp=1010/8", out_pc, imm); end
        in_valid = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_stall;
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h00100093; in_pc = 32'h0000_2000;                    // A
        tick;
        checks++; if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b1, 32'h2000}) begin failures++; $display("FAIL stall_a got=%b%b/%h exp=11/2000", out_valid, in_ready, out_pc); end
        in_inst = 32'h00200093; in_pc = 32'h0000_2004;                    // B
        tick;
        checks++; if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b0, 32'h2000}) begin failures++; $display("FAIL stall_b got=%b%b/%h exp=10/2000", out_valid, in_ready, out_pc); end
        in_inst = 32'h00300093; in_pc = 32'h0000_2008;                    // C, must wait
        tick;
        checks++; if ({out_valid, in_ready, out_pc, imm} !== {1'b1, 1'b0, 32'h2000, 32'd1}) begin failures++; $display("FAIL stall_hold got=%b%b/%h/%h exp=10/2000/1", out_valid, in_ready, out_pc, imm); end
        out_ready = 1'b1;
        tick;
        checks++; if ({out_valid, in_ready, out_pc, imm} !== {1'b1, 1'b1, 32'h2004, 32'd2}) begin failures++; $display("FAIL release_b got=%b%b/%h/%h exp=11/2004/2", out_valid, in_ready, out_pc, imm); end
        tick;
        checks++; if ({out_valid, in_ready, out_pc, imm} !== {1'b1, 1'b1, 32'h2008, 32'd3}) begin failures++; $display("FAIL release_c got=%b%b/%h/%h exp=11/2008/3", out_valid, in_ready, out_pc, imm); end
        in_valid = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_empty got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h00400093; in_pc = 32'h0000_3000; tick;              // D
        in_inst = 32'h00500093; in_pc = 32'h0000_3004; tick;              // E
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%0b exp=0", in_ready); end
        flush = 1'b1; in_inst = 32'h00600093; in_pc = 32'h0000_3008;      // F, dropped
        tick;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL flush_state got=%b%b exp=01", out_valid, in_ready); end
        checks++; if (out_pc !== 32'h3000) begin failures++; $display("FAIL flush_retain got=%h exp=3000", out_pc); end
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stays_empty got=%0b exp=0", out_valid); end
        in_valid = 1'b1; in_inst = 32'h00700093; in_pc = 32'h0000_300C;   // G
        tick;
        in_valid = 1'b0;
        checks++; if ({out_valid, out_pc, imm} !== {1'b1, 32'h300C, 32'd7}) begin failures++; $display("FAIL flush_next got=%b/%h/%h exp=1/300c/7", out_valid, out_pc, imm); end
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_dup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_inst = {12'd10 + 12'(i), 20'h00093};
            in_pc = 32'h4000 + 32'(i * 4);
            tick;
            checks++;
            if ({out_valid, in_ready, out_pc, imm} !== {1'b1, 1'b1, 32'h4000 + 32'(i * 4), 32'd10 + 32'(i)}) begin
                failures++; $display("FAIL b2b_%0d got=%b%b/%h/%h", i, out_valid, in_ready, out_pc, imm);
            end
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h0020A423; in_pc = 32'h5000; tick;
        in_inst = 32'hFE000EE3; in_pc = 32'h5004; tick;
        in_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if ({out_valid, in_ready, out_pc, imm, fmt} !== {1'b0, 1'b1, 32'd0, 32'd0, 3'd0}) begin failures++; $display("FAIL mid_reset got=%b%b/%h/%h/%0d exp=01/0/0/0", out_valid, in_ready, out_pc, imm, fmt); end
        out_ready = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_drop got=%0b exp=0", out_valid); end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1; in_valid = 1'b1;
        in_inst = 32'h00000000; in_pc = 32'h6000;
        tick;
        checks++; if ({out_valid, illegal, fmt, imm} !== {1'b1, ILL_EN, 3'd0, 32'd0}) begin failures++; $display("FAIL illegal_zero got=%b%b/%0d/%h exp=1%b/0/0", out_valid, illegal, fmt, imm, ILL_EN); end
        in_inst = 32'hFFF00001;
        tick;
        checks++; if ({illegal, fmt, imm} !== {ILL_EN, 3'd0, 32'd0}) begin failures++; $display("FAIL illegal_lowbits got=%b/%0d/%h exp=%b/0/0", illegal, fmt, imm, ILL_EN); end
        in_inst = 32'h00500093;
        tick;
        in_valid = 1'b0;
        checks++; if ({illegal, fmt, imm} !== {1'b0, 3'd1, 32'd5}) begin failures++; $display("FAIL illegal_clear got=%b/%0d/%h exp=0/1/5", illegal, fmt, imm); end
        tick;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stall();
        test_flush();
        test_back_to_back();
        test_mid_reset();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
